hash_io_adapter: RTL and testbench

Parametrised stream adapter between the byte-serial host interface and the hash core. It packs `IN_W`-bit input words into one `BLOCK_BITS` message block and hands the block to the core over a valid/ready handshake. It then captures the `DIGEST_BITS` digest and serialises it as `OUT_W`-bit words. It generalises the fixed 8-bit-in / 16-bit-out path of the Hash160 top by adding parametrised widths, input backpressure (`i_ready`) and output backpressure (`o_ready`).

---
 rtl/hash_pkg.sv | 28 ++
 rtl/digest_serializer.sv | 71 +++++++
 rtl/hash_io_adapter.sv | 115 +++++++++++
 tb/tb_hash_io_adapter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared types, default widths and derived-count helpers for the hash I/O adapter.
package hash_pkg;

  localparam int unsigned HASH_IN_W        = 8;
  localparam int unsigned HASH_BLOCK_BITS  = 512;
  localparam int unsigned HASH_OUT_W       = 16;
  localparam int unsigned HASH_DIGEST_BITS = 160;

  // Adapter phases: pack input words, hand block to core, await digest, emit digest.
  typedef enum logic [1:0] {
    StFill,
    StIssue,
    StWait,
    StDrain
  } hio_state_t;

  // Input words per message block.
  function automatic int unsigned n_in(input int unsigned block_bits, input int unsigned in_w);
    return block_bits / in_w;
  endfunction

  // Output words per digest.
  function automatic int unsigned n_out(input int unsigned digest_bits,
                                        input int unsigned out_w);
    return digest_bits / out_w;
  endfunction

endpackage

// File: rtl/digest_serializer.sv
// Parallel-load digest shift register; emits OUT_W-bit words MSB first over valid/ready.
module digest_serializer
  import hash_pkg::*;
#(
  parameter int unsigned OUT_W       = HASH_OUT_W,
  parameter int unsigned DIGEST_BITS = HASH_DIGEST_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [DIGEST_BITS-1:0] data_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [OUT_W-1:0]       word_o,
  output logic                   done_o
);

  localparam int unsigned NOut = n_out(DIGEST_BITS, OUT_W);
  localparam int unsigned CntW = $clog2(NOut) + 1;

  if ((DIGEST_BITS % OUT_W) != 0) begin : gen_bad_out_w
    $error("OUT_W must divide DIGEST_BITS");
  end

  logic [DIGEST_BITS-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   accept;
  logic                   last_word;

  assign accept    = valid_q && ready_i;
  assign last_word = (cnt_q == CntW'(NOut - 1));
  // Final word leaves this cycle; the top returns to filling on the same edge.
  assign done_o    = accept && last_word;

  // Next state: load a fresh digest, or shift one word out per accepted beat.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      shreg_d = shreg_q << OUT_W;
      if (last_word) begin
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = shreg_q[DIGEST_BITS-1 -: OUT_W];

endmodule

// File: rtl/hash_io_adapter.sv
// Packs IN_W-bit host words into a message block for the hash core and serialises the
// returned digest as OUT_W-bit words, with backpressure on both sides.
module hash_io_adapter
  import hash_pkg::*;
#(
  parameter int unsigned IN_W        = HASH_IN_W,
  parameter int unsigned BLOCK_BITS  = HASH_BLOCK_BITS,
  parameter int unsigned OUT_W       = HASH_OUT_W,
  parameter int unsigned DIGEST_BITS = HASH_DIGEST_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [IN_W-1:0]        i_text,
  output logic                   i_ready,
  output logic                   blk_valid,
  output logic [BLOCK_BITS-1:0]  blk_data,
  input  logic                   blk_ready,
  input  logic                   dig_valid,
  input  logic [DIGEST_BITS-1:0] dig_data,
  output logic                   o_valid,
  output logic [OUT_W-1:0]       o_answer,
  input  logic                   o_ready
);

  localparam int unsigned NIn    = n_in(BLOCK_BITS, IN_W);
  localparam int unsigned InCntW = $clog2(NIn) + 1;

  if ((BLOCK_BITS % IN_W) != 0) begin : gen_bad_in_w
    $error("IN_W must divide BLOCK_BITS");
  end

  hio_state_t            state_q;
  logic                  i_ready_q;
  logic                  blk_valid_q;
  logic [BLOCK_BITS-1:0] blk_data_q;
  logic [InCntW-1:0]     in_cnt_q;
  logic                  ser_load;
  logic                  ser_done;

  // Digest is only captured while waiting on the core; strays elsewhere are dropped.
  assign ser_load = (state_q == StWait) && dig_valid;

  // Phase control, block packing and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      i_ready_q   <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_data_q  <= '0;
      in_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          i_ready_q <= 1'b1;
          if (i_valid && i_ready_q) begin
            // Word k lands at the k-th slot from the top, so the first word is the MSBs.
            for (int unsigned k = 0; k < NIn; k++) begin
              if (in_cnt_q == InCntW'(k)) begin
                blk_data_q[BLOCK_BITS-1-k*IN_W -: IN_W] <= i_text;
              end
            end
            if (in_cnt_q == InCntW'(NIn - 1)) begin
              state_q     <= StIssue;
              i_ready_q   <= 1'b0;
              blk_valid_q <= 1'b1;
              in_cnt_q    <= '0;
            end else begin
              in_cnt_q <= in_cnt_q + InCntW'(1);
            end
          end
        end
        StIssue: begin
          if (blk_ready) begin
            state_q     <= StWait;
            blk_valid_q <= 1'b0;
          end
        end
        StWait: begin
          if (dig_valid) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // Re-open the input on the last output beat so messages can run back to back.
          if (ser_done) begin
            state_q   <= StFill;
            i_ready_q <= 1'b1;
            in_cnt_q  <= '0;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  digest_serializer #(
    .OUT_W       (OUT_W),
    .DIGEST_BITS (DIGEST_BITS)
  ) u_digest_serializer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load),
    .data_i  (dig_data),
    .ready_i (o_ready),
    .valid_o (o_valid),
    .word_o  (o_answer),
    .done_o  (ser_done)
  );

  assign i_ready   = i_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_data_q;

endmodule

// File: tb/tb_hash_io_adapter.sv
// Directed bench for hash_io_adapter: default 8/16 instance plus a 32/32 instance.
module tb_hash_io_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  // Default-width instance
  logic         i_valid = 1'b0;
  logic [7:0]   i_text = '0;
  logic         i_ready;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_ready = 1'b0;
  logic         dig_valid = 1'b0;
  logic [159:0] dig_data = '0;
  logic         o_valid;
  logic [15:0]  o_answer;
  logic         o_ready = 1'b1;
  // 32-bit in / 32-bit out instance
  logic         w_i_valid = 1'b0;
  logic [31:0]  w_i_text = '0;
  logic         w_i_ready;
  logic         w_blk_valid;
  logic [511:0] w_blk_data;
  logic         w_blk_ready = 1'b0;
  logic         w_dig_valid = 1'b0;
  logic [159:0] w_dig_data = '0;
  logic         w_o_valid;
  logic [31:0]  w_o_answer;
  logic         w_o_ready = 1'b1;

  hash_io_adapter dut (
    .clk (clk), .rst_n (rst_n),
    .i_valid (i_valid), .i_text (i_text), .i_ready (i_ready),
    .blk_valid (blk_valid), .blk_data (blk_data), .blk_ready (blk_ready),
    .dig_valid (dig_valid), .dig_data (dig_data),
    .o_valid (o_valid), .o_answer (o_answer), .o_ready (o_ready)
  );

  hash_io_adapter #(
    .IN_W (32), .BLOCK_BITS (512), .OUT_W (32), .DIGEST_BITS (160)
  ) dut32 (
    .clk (clk), .rst_n (rst_n),
    .i_valid (w_i_valid), .i_text (w_i_text), .i_ready (w_i_ready),
    .blk_valid (w_blk_valid), .blk_data (w_blk_data), .blk_ready (w_blk_ready),
    .dig_valid (w_dig_valid), .dig_data (w_dig_data),
    .o_valid (w_o_valid), .o_answer (w_o_answer), .o_ready (w_o_ready)
  );

  localparam logic [159:0] D1 = 160'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C;
  localparam logic [159:0] D2 = 160'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0_8001_7FFE;
  localparam logic [159:0] D3 = 160'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0001;

  typedef struct {
    logic [7:0]   base;
    bit           gap;
    int           stall;
    int           omode;
    logic [159:0] digest;
    logic [7:0]   exp_top;
    logic [7:0]   exp_low;
    logic [15:0]  exp_first;
    logic [15:0]  exp_last;
  } vec_t;

  vec_t vecs[4];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] blk_model(input logic [7:0] base);
    logic [511:0] b = '0;
    for (int k = 0; k < 64; k++) b[511-8*k -: 8] = base + 8'(k);
    return b;
  endfunction

  // Asynchronous reset taken between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_i_ready"}, i_ready, 0);
    chk({tag, "_rst_blk_valid"}, blk_valid, 0);
    chk({tag, "_rst_o_valid"}, o_valid, 0);
    chk({tag, "_rst_blk_data"}, blk_data, 0);
    chk({tag, "_rst_o_answer"}, o_answer, 0);
    i_valid = 1'b0; dig_valid = 1'b0; blk_ready = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk({tag, "_i_ready_rise"}, i_ready, 1);
  endtask

  // Feed words base, base+1, ...; gap mode drops i_valid every other cycle.
  task automatic fill(input logic [7:0] base, input bit gap, input int nwords,
                      output bit drop);
    int k = 0;
    int cyc = 0;
    bit acc;
    drop = 1'b0;
    while (k < nwords && cyc < 400) begin
      i_valid = !(gap && (cyc % 2 == 1));
      i_text  = base + 8'(k);
      if (!i_ready) drop = 1'b1;
      acc = i_valid && i_ready;
      tick();
      cyc++;
      if (acc) k++;
    end
    i_valid = 1'b0;
    if (k < nwords) chk("fill_timeout", k, nwords);
  endtask

  // Hold blk_ready low for 'stall' cycles while pushing ignored input, then hand over.
  task automatic issue(input int stall, input logic [511:0] exp_blk);
    for (int s = 0; s < stall; s++) begin
      blk_ready = 1'b0;
      i_valid = 1'b1;
      i_text = 8'hEE;
      tick();
      chk("stall_blk_valid", blk_valid, 1);
      chk("stall_blk_data", blk_data, exp_blk);
      chk("stall_i_ready", i_ready, 0);
    end
    i_valid = 1'b0;
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    chk("blk_valid_fall", blk_valid, 0);
  endtask

  task automatic give_digest(input logic [159:0] d, input logic [15:0] exp_first);
    tick();
    chk("wait_o_valid", o_valid, 0);
    dig_data = d;
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    dig_data = '0;
    chk("dig_o_valid", o_valid, 1);
    chk("dig_first", o_answer, exp_first);
  endtask

  // Collect up to 'stop' words; omode 1 applies o_ready pattern 1,0,0 repeating.
  task automatic drain(input int omode, input logic [159:0] d, input int stop,
                       input logic [15:0] exp_last);
    int got = 0;
    int cyc = 0;
    int vcyc = 0;
    bit hold_err = 1'b0;
    bit ov, rdy;
    logic [15:0] prev;
    logic [15:0] last = '0;
    while (got < stop && cyc < 200) begin
      o_ready = (omode == 0) ? 1'b1 : (cyc % 3 == 0);
      prev = o_answer;
      ov = o_valid;
      rdy = o_ready;
      if (ov) vcyc++;
      tick();
      cyc++;
      if (ov && rdy) begin
        chk($sformatf("word%0d", got), prev, d[159-16*got -: 16]);
        last = prev;
        got++;
      end else if (ov && o_answer !== prev) begin
        hold_err = 1'b1;
      end
    end
    o_ready = 1'b1;
    chk("words_delivered", got, stop);
    chk("answer_hold", hold_err, 0);
    if (stop == 10) begin
      chk("last_word", last, exp_last);
      chk("valid_cycles", vcyc, (omode == 0) ? 10 : 28);
      chk("drain_o_valid_end", o_valid, 0);
      chk("drain_i_ready_end", i_ready, 1);
    end
  endtask

  initial begin
    bit drop;
    logic [31:0] wexp[5];

    vecs[0] = '{8'h00, 1'b0, 0, 0, D1, 8'h00, 8'h3F, 16'h0123, 16'h2D3C};
    vecs[1] = '{8'h00, 1'b1, 5, 1, D2, 8'h00, 8'h3F, 16'hDEAD, 16'h7FFE};
    vecs[2] = '{8'hC0, 1'b0, 1, 1, D3, 8'hC0, 8'hFF, 16'h8000, 16'h0001};
    vecs[3] = '{8'h41, 1'b1, 0, 0, D1, 8'h41, 8'h80, 16'h0123, 16'h2D3C};

    do_reset("init");

    // Table-driven full transactions
    for (int v = 0; v < 4; v++) begin
      blk_ready = (vecs[v].stall == 0);
      fill(vecs[v].base, vecs[v].gap, 64, drop);
      chk("i_ready_held", drop, 0);
      chk("blk_valid_rise", blk_valid, 1);
      chk("i_ready_issue", i_ready, 0);
      chk("blk_top", blk_data[511:504], vecs[v].exp_top);
      chk("blk_low", blk_data[7:0], vecs[v].exp_low);
      chk("blk_data", blk_data, blk_model(vecs[v].base));
      issue(vecs[v].stall, blk_model(vecs[v].base));
      give_digest(vecs[v].digest, vecs[v].exp_first);
      drain(vecs[v].omode, vecs[v].digest, 10, vecs[v].exp_last);
    end

    // Spurious dig_valid in FILL and in ISSUE
    fill(8'h00, 1'b0, 20, drop);
    dig_data = D2;
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    chk("spur_fill_o_valid", o_valid, 0);
    chk("spur_fill_i_ready", i_ready, 1);
    fill(8'h14, 1'b0, 44, drop);
    chk("spur_blk_data", blk_data, blk_model(8'h00));
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    chk("spur_issue_o_valid", o_valid, 0);
    chk("spur_issue_blk_valid", blk_valid, 1);
    issue(0, blk_model(8'h00));
    give_digest(D1, 16'h0123);
    drain(0, D1, 10, 16'h2D3C);

    // Reset mid-FILL
    fill(8'h00, 1'b0, 30, drop);
    do_reset("mid_fill");
    fill(8'h80, 1'b0, 64, drop);
    chk("after_fill_rst_blk", blk_data, blk_model(8'h80));
    issue(0, blk_model(8'h80));
    give_digest(D2, 16'hDEAD);
    drain(0, D2, 4, 16'h0000);
    // Reset mid-DRAIN after four words
    chk("mid_drain_o_valid", o_valid, 1);
    do_reset("mid_drain");
    tick();
    chk("post_rst_o_valid", o_valid, 0);
    fill(8'h33, 1'b1, 64, drop);
    chk("after_drain_rst_blk", blk_data, blk_model(8'h33));
    issue(0, blk_model(8'h33));
    give_digest(D3, 16'h8000);
    drain(0, D3, 10, 16'h0001);

    // Wide instance: 16 input words, 5 output words, MSB first
    for (int k = 0; k < 16; k++) begin
      w_i_valid = 1'b1;
      w_i_text = 32'hA000_0000 + 32'(k);
      tick();
    end
    w_i_valid = 1'b0;
    chk("w_blk_valid", w_blk_valid, 1);
    chk("w_blk_top", w_blk_data[511:480], 32'hA000_0000);
    chk("w_blk_second", w_blk_data[479:448], 32'hA000_0001);
    chk("w_blk_low", w_blk_data[31:0], 32'hA000_000F);
    w_blk_ready = 1'b1;
    tick();
    w_blk_ready = 1'b0;
    chk("w_blk_valid_fall", w_blk_valid, 0);
    w_dig_data = D1;
    w_dig_valid = 1'b1;
    tick();
    w_dig_valid = 1'b0;
    wexp[0] = 32'h0123_4567;
    wexp[1] = 32'h89AB_CDEF;
    wexp[2] = 32'hFEDC_BA98;
    wexp[3] = 32'h7654_3210;
    wexp[4] = 32'h0F1E_2D3C;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("w_o_valid%0d", k), w_o_valid, 1);
      chk($sformatf("w_word%0d", k), w_o_answer, wexp[k]);
      tick();
    end
    chk("w_o_valid_end", w_o_valid, 0);
    chk("w_i_ready_end", w_i_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
